cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/lc3b_types.sv | 8 +
 rtl/cache_perf_counter.sv | 28 ++
 rtl/cache_control.sv | 156 +++++++++++++++
 tb/tb_cache_control.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used across the cache slice.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [2:0]  lc3b_index;
    typedef logic [8:0]  lc3b_tag;

endpackage : lc3b_types

// File: rtl/cache_perf_counter.sv
// Saturating event counter with synchronous clear and asynchronous reset.
module cache_perf_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Count events, holding at all-ones; clear wins over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule : cache_perf_counter

// File: rtl/cache_control.sv
// Write-back, write-allocate cache controller FSM with hit/miss counters.
module cache_control
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic                 hit,
    input  logic                 dirty,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic                 pmem_addr_sel,
    output logic                 data_sel,
    output logic                 load_data,
    output logic                 load_tag,
    output logic                 load_valid,
    output logic                 load_dirty,
    output logic                 dirty_in,
    input  logic                 clear_counts,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   miss_pend;
    logic   miss_exit;
    logic   req;

    // Ungated decode; every output is forced low while reset is high.
    logic resp_raw, pmem_read_raw, pmem_write_raw, addr_sel_raw, data_sel_raw;
    logic load_data_raw, load_tag_raw, load_valid_raw, load_dirty_raw, dirty_in_raw;

    assign req = mem_read | mem_write;

    // Next-state and output decode; a simultaneous read+write follows the write path.
    always_comb begin
        next_state     = state;
        miss_exit      = 1'b0;
        resp_raw       = 1'b0;
        pmem_read_raw  = 1'b0;
        pmem_write_raw = 1'b0;
        addr_sel_raw   = 1'b0;
        data_sel_raw   = 1'b0;
        load_data_raw  = 1'b0;
        load_tag_raw   = 1'b0;
        load_valid_raw = 1'b0;
        load_dirty_raw = 1'b0;
        dirty_in_raw   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && hit) begin
                    resp_raw = 1'b1;
                    if (mem_write) begin
                        load_data_raw  = 1'b1;
                        load_dirty_raw = 1'b1;
                        dirty_in_raw   = 1'b1;
                    end else begin
                        load_data_raw  = 1'b0;
                    end
                end else if (req) begin
                    miss_exit  = 1'b1;
                    next_state = dirty ? S_WRITEBACK : S_ALLOCATE;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                pmem_write_raw = 1'b1;
                addr_sel_raw   = 1'b1;
                if (pmem_resp) begin
                    next_state = S_ALLOCATE;
                end else begin
                    next_state = S_WRITEBACK;
                end
            end
            S_ALLOCATE: begin
                pmem_read_raw = 1'b1;
                if (pmem_resp) begin
                    load_data_raw  = 1'b1;
                    data_sel_raw   = 1'b1;
                    load_tag_raw   = 1'b1;
                    load_valid_raw = 1'b1;
                    load_dirty_raw = 1'b1;
                    next_state     = S_IDLE;
                end else begin
                    next_state = S_ALLOCATE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign mem_resp      = resp_raw       & ~reset;
    assign pmem_read     = pmem_read_raw  & ~reset;
    assign pmem_write    = pmem_write_raw & ~reset;
    assign pmem_addr_sel = addr_sel_raw   & ~reset;
    assign data_sel      = data_sel_raw   & ~reset;
    assign load_data     = load_data_raw  & ~reset;
    assign load_tag      = load_tag_raw   & ~reset;
    assign load_valid    = load_valid_raw & ~reset;
    assign load_dirty    = load_dirty_raw & ~reset;
    assign dirty_in      = dirty_in_raw   & ~reset;

    // State register; reset abandons any in-flight pmem transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Remember that the current request missed so its eventual response is not counted as a hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_pend <= 1'b0;
        end else if (miss_exit) begin
            miss_pend <= 1'b1;
        end else if (resp_raw) begin
            miss_pend <= 1'b0;
        end else begin
            miss_pend <= miss_pend;
        end
    end

    cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (resp_raw & ~miss_pend),
        .clr   (clear_counts),
        .count (hit_count)
    );

    cache_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (miss_exit),
        .clr   (clear_counts),
        .count (miss_count)
    );

endmodule : cache_control

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed table, corner sequences, random vs model.
module tb_cache_control;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int OP_WB   = 1;
    localparam int OP_FILL = 2;

    logic clk = 1'b0;
    logic reset, mem_read, mem_write, hit, dirty, pmem_resp, clear_counts;
    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel;
    logic load_data, load_tag, load_valid, load_dirty, dirty_in;
    logic [CW-1:0] hit_count, miss_count;
    logic [9:0] outs;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending physical-memory operations plus counter values.
    int ops[$];
    int m_hit, m_miss;
    bit m_pend;

    logic [9:0]    obs_outs;
    logic [CW-1:0] obs_hit, obs_miss;

    always #5 clk = ~clk;

    cache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .hit(hit), .dirty(dirty), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel),
        .data_sel(data_sel), .load_data(load_data), .load_tag(load_tag),
        .load_valid(load_valid), .load_dirty(load_dirty), .dirty_in(dirty_in),
        .clear_counts(clear_counts), .hit_count(hit_count), .miss_count(miss_count)
    );

    // {mem_resp, pmem_read, pmem_write, addr_sel, data_sel, load_data, load_tag, load_valid, load_dirty, dirty_in}
    assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel,
                   load_data, load_tag, load_valid, load_dirty, dirty_in};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ops.delete();
        m_hit  = 0;
        m_miss = 0;
        m_pend = 1'b0;
    endtask

    // One clock: drive, check against the model before the edge, advance the model at the edge.
    task automatic cycle(input logic rd, input logic wr, input logic h, input logic d,
                         input logic pr, input logic cc, input string tag);
        logic [9:0] eo;
        bit miss;
        mem_read = rd; mem_write = wr; hit = h; dirty = d; pmem_resp = pr; clear_counts = cc;
        #2;
        eo = '0;
        miss = 1'b0;
        if (ops.size() == 0) begin
            if ((rd || wr) && h) begin
                eo[9] = 1'b1;
                if (wr) begin eo[4] = 1'b1; eo[1] = 1'b1; eo[0] = 1'b1; end
            end else if (rd || wr) begin
                miss = 1'b1;
            end
        end else if (ops[0] == OP_WB) begin
            eo[7] = 1'b1; eo[6] = 1'b1;
        end else begin
            eo[8] = 1'b1;
            if (pr) begin eo[5] = 1'b1; eo[4] = 1'b1; eo[3] = 1'b1; eo[2] = 1'b1; eo[1] = 1'b1; end
        end
        obs_outs = outs; obs_hit = hit_count; obs_miss = miss_count;
        chk({tag, ".outs"}, 32'(outs), 32'(eo));
        chk({tag, ".hit_count"}, 32'(hit_count), 32'(m_hit));
        chk({tag, ".miss_count"}, 32'(miss_count), 32'(m_miss));
        chk({tag, ".pmem_excl"}, 32'(pmem_read & pmem_write), 32'd0);
        @(posedge clk);
        if (ops.size() == 0) begin
            if (miss) begin
                if (d) ops.push_back(OP_WB);
                ops.push_back(OP_FILL);
            end
        end else if (pr) begin
            void'(ops.pop_front());
        end
        if (cc) begin
            m_hit = 0; m_miss = 0;
        end else begin
            if (miss && m_miss < CMAX) m_miss++;
            if (eo[9] && !m_pend && m_hit < CMAX) m_hit++;
        end
        if (miss) m_pend = 1'b1;
        else if (eo[9]) m_pend = 1'b0;
        #1;
    endtask

    typedef struct {
        logic rd, wr, h, d, pr, cc;
        logic [9:0] exp_outs;
        int exp_hit, exp_miss;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rd, logic wr, logic h, logic d, logic pr, logic cc,
                                logic [9:0] eo, int eh, int em);
        vec_t v;
        v.rd = rd; v.wr = wr; v.h = h; v.d = d; v.pr = pr; v.cc = cc;
        v.exp_outs = eo; v.exp_hit = eh; v.exp_miss = em;
        return v;
    endfunction

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 1'b0; dirty = 1'b0;
        pmem_resp = 1'b0; clear_counts = 1'b0;
        model_reset();
        #2;
        chk("reset.outs", 32'(outs), 32'd0);
        chk("reset.hit_count", 32'(hit_count), 32'd0);
        chk("reset.miss_count", 32'(miss_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Directed table from a fresh reset: rd, wr, hit, dirty, pmem_resp, clear, outs, hits, misses
        tbl.push_back(mk(0,0,0,0,0,0, 10'b0000000000, 0, 0));
        tbl.push_back(mk(1,0,1,0,0,0, 10'b1000000000, 0, 0)); // read hit, same-cycle resp
        tbl.push_back(mk(0,0,0,0,0,0, 10'b0000000000, 1, 0));
        tbl.push_back(mk(0,1,0,1,0,0, 10'b0000000000, 1, 0)); // dirty write miss
        tbl.push_back(mk(0,1,0,1,0,0, 10'b0011000000, 1, 1)); // writeback x3
        tbl.push_back(mk(0,1,0,1,0,0, 10'b0011000000, 1, 1));
        tbl.push_back(mk(0,1,0,1,1,0, 10'b0011000000, 1, 1));
        tbl.push_back(mk(0,1,0,1,0,0, 10'b0100000000, 1, 1)); // allocate x3
        tbl.push_back(mk(0,1,0,1,0,0, 10'b0100000000, 1, 1));
        tbl.push_back(mk(0,1,0,1,1,0, 10'b0100111110, 1, 1)); // fill strobes, dirty_in=0
        tbl.push_back(mk(0,1,1,0,0,0, 10'b1000010011, 1, 1)); // write now hits
        tbl.push_back(mk(0,0,0,0,0,0, 10'b0000000000, 1, 1)); // miss response not a hit
        tbl.push_back(mk(1,0,0,0,0,0, 10'b0000000000, 1, 1)); // clean read miss
        tbl.push_back(mk(0,0,0,0,0,0, 10'b0100000000, 1, 2)); // dropped in allocate
        tbl.push_back(mk(0,0,0,0,1,0, 10'b0100111110, 1, 2)); // fill still completes
        tbl.push_back(mk(0,0,0,0,0,0, 10'b0000000000, 1, 2)); // no mem_resp
        tbl.push_back(mk(1,0,1,0,0,0, 10'b1000000000, 1, 2)); // clears stale miss_pend
        tbl.push_back(mk(0,0,0,0,0,0, 10'b0000000000, 1, 2));
        tbl.push_back(mk(1,0,1,0,0,0, 10'b1000000000, 1, 2));
        tbl.push_back(mk(0,0,0,0,0,0, 10'b0000000000, 2, 2));
        tbl.push_back(mk(1,1,1,0,0,0, 10'b1000010011, 2, 2)); // read+write acts as write
        tbl.push_back(mk(0,0,0,0,1,0, 10'b0000000000, 3, 2)); // pmem_resp ignored in idle
        tbl.push_back(mk(0,0,0,0,0,0, 10'b0000000000, 3, 2));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].rd, tbl[i].wr, tbl[i].h, tbl[i].d, tbl[i].pr, tbl[i].cc, $sformatf("model%0d", i));
            chk($sformatf("tbl%0d.outs", i), 32'(obs_outs), 32'(tbl[i].exp_outs));
            chk($sformatf("tbl%0d.hit_count", i), 32'(obs_hit), 32'(tbl[i].exp_hit));
            chk($sformatf("tbl%0d.miss_count", i), 32'(obs_miss), 32'(tbl[i].exp_miss));
        end

        // Reset while in writeback with the request still held.
        cycle(0,1,0,1,0,0, "rstwb.miss");
        cycle(0,1,0,1,0,0, "rstwb.wb");
        chk("rstwb.pmem_write_before", 32'(obs_outs[7]), 32'd1);
        reset = 1'b1;
        #2;
        chk("rstwb.outs", 32'(outs), 32'd0);
        chk("rstwb.hit_count", 32'(hit_count), 32'd0);
        chk("rstwb.miss_count", 32'(miss_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        cycle(0,0,0,0,1,0, "rstwb.idle_after");
        chk("rstwb.idle_outs", 32'(obs_outs), 32'd0);

        // Saturation with a narrow counter, then clear racing a hit.
        for (int i = 0; i < 17; i++) cycle(1,0,1,0,0,0, "sat");
        cycle(0,0,0,0,0,0, "sat.idle");
        chk("sat.hit_count", 32'(obs_hit), 32'd15);
        cycle(1,0,1,0,0,1, "clr.hit");
        cycle(0,0,0,0,0,0, "clr.after");
        chk("clr.hit_count", 32'(obs_hit), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule : tb_cache_control
